instr_decoder: RTL and testbench
================================

Name: instr_decoder

Overview:
Parametrised, pipelined successor to the CPU's single-word instruction decoder. It accepts instruction words over a valid/ready stream from program memory and splits each word into opcode, destination, source_1 and source_2, MSB first. It classifies the opcode as ALU, immediate-carrying or illegal. Immediate-carrying opcodes consume a second stream word as a full-width immediate, and the decoded result is presented through a registered valid/ready output stage feeding the CPU datapath.

Parameters:
INSTRUCTION_WIDTH, 32, width of instruction and immediate words
OPCODE_WIDTH, 5, opcode field width (top bits)
OPERAND_WIDTH, 9, width of each of destination/source_1/source_2
ALU_OP_LO, 1, lowest ALU opcode (inclusive)
ALU_OP_HI, 19, highest ALU opcode (inclusive)
IMM_OP_LO, 20, lowest opcode that carries an immediate word
IMM_OP_HI, 23, highest opcode that carries an immediate word
LAST_VALID_OP, 27, opcodes above this are illegal
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of pending and output state
in_valid  input  1  instruction word valid
in_ready  output  1  decoder accepts word this cycle
in_data  input  INSTRUCTION_WIDTH  instruction or immediate word
out_valid  output  1  decoded instruction valid
out_ready  input  1  consumer accepts decoded instruction
opcode  output  OPCODE_WIDTH  in_data[MSB -: OPCODE_WIDTH]
destination  output  OPERAND_WIDTH  next field down
source_1  output  OPERAND_WIDTH  next field down
source_2  output  OPERAND_WIDTH  lowest field
immediate  output  INSTRUCTION_WIDTH  immediate word, 0 if none
is_alu  output  1  ALU_OP_LO <= opcode <= ALU_OP_HI
has_imm  output  1  IMM_OP_LO <= opcode <= IMM_OP_HI
illegal  output  1  opcode > LAST_VALID_OP
instr_count  output  COUNT_WIDTH  count of output handshakes

Behaviour:
- Elaboration check: OPCODE_WIDTH + 3*OPERAND_WIDTH == INSTRUCTION_WIDTH. The check also requires the ALU range, the IMM range and LAST_VALID_OP to be ordered and non-overlapping. Any violation gives a fatal elaboration error.
- Reset (rst_n low, async): state=S_OP, out_valid=0, all data outputs 0, instr_count=0, pending regs 0.
- out_free = !out_valid || out_ready. in_ready = out_free, combinational, in both states.
- Accept = in_valid && in_ready.
- FSM states: S_OP, S_IMM.
- S_OP, accept of a non-immediate opcode: load the output regs from the fields; immediate=0; compute the flags; out_valid=1 next cycle; stay in S_OP.
- S_OP, accept of an immediate opcode: latch the fields into pending regs; out_valid goes to 0 if out_ready consumed the current result, otherwise it is unchanged; go to S_IMM.
- S_IMM, accept: the whole in_data is taken as the immediate, never decoded. Load the output regs from pending + immediate; has_imm=1; out_valid=1; go to S_OP.
- Latency: 1 cycle from accepting the final word of an instruction to out_valid.
- Output stage: when out_valid && !out_ready, all outputs hold stable. When out_valid && out_ready with no new load, out_valid goes to 0 next cycle.
- Full throughput: back-to-back single-word instructions with out_ready=1 give one result per cycle.
- Illegal opcode: decoded as a single word; illegal=1, is_alu=0, has_imm=0; the immediate fetch is never entered.
- Opcode 0 (NOP): decoded with all flags 0.
- instr_count increments on each out_valid && out_ready and wraps modulo 2^COUNT_WIDTH.
- flush (priority over accept): state=S_OP, out_valid=0, pending discarded, in_ready still follows the out_free of this cycle but the accepted word is dropped. instr_count is not cleared.
- Reset mid-S_IMM: returns to S_OP and discards the pending opcode.

Decomposition:
- Package cpu_decode_pkg holds:
  - state enum {S_OP, S_IMM}
  - default opcode-range localparams
  - packed struct decoded_t (opcode, destination, source_1, source_2, immediate, is_alu, has_imm, illegal), parametrised via the package's default widths.
- One natural sub-module: opcode_classifier, purely combinational, taking opcode and producing is_alu/has_imm/illegal. It is reused by the later hazard unit.

Test Plan:
- Reset, then in_data=0x18140E09 valid with out_ready=1 -> next cycle out_valid=1, opcode=3, destination=5, source_1=7, source_2=9, is_alu=1, immediate=0, instr_count becomes 1 after the handshake.
- in_data=0xA0040000 then 0xDEADBEEF -> after the second word, opcode=20, destination=1, has_imm=1, immediate=0xDEADBEEF; no out_valid between the two words.
- in_data=0xF0000000 -> illegal=1, is_alu=0, has_imm=0, decoded as a single word (the next word is decoded as a new instruction).
- out_ready=0 with result held, new in_valid -> in_ready=0, outputs stable 5 cycles; release out_ready -> queued word decoded next cycle, no loss or duplication.
- Immediate opcode accepted, then flush before the immediate word -> state S_OP, out_valid=0; the next word 0x18140E09 is decoded as an opcode.
- Drive 65537 back-to-back single-word instructions -> instr_count wraps to 1; rst_n pulse low mid-S_IMM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared decode types: FSM state, default field widths, opcode ranges
// and the decoded instruction bundle passed toward the datapath.
package cpu_decode_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned OPND_W   = 9;
  localparam int unsigned CNT_W    = 16;

  localparam int unsigned ALU_LO   = 1;
  localparam int unsigned ALU_HI   = 19;
  localparam int unsigned IMM_LO   = 20;
  localparam int unsigned IMM_HI   = 23;
  localparam int unsigned LAST_OP  = 27;

  typedef enum logic [0:0] {
    S_OP,
    S_IMM
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [OPND_W-1:0]  destination;
    logic [OPND_W-1:0]  source_1;
    logic [OPND_W-1:0]  source_2;
    logic [INSTR_W-1:0] immediate;
    logic               is_alu;
    logic               has_imm;
    logic               illegal;
  } decoded_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode range check: opcode -> is_alu / has_imm / illegal.
// Ports: opcode in; is_alu, has_imm, illegal out.
module opcode_classifier
  import cpu_decode_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH  = OPC_W,
  parameter int unsigned ALU_OP_LO     = ALU_LO,
  parameter int unsigned ALU_OP_HI     = ALU_HI,
  parameter int unsigned IMM_OP_LO     = IMM_LO,
  parameter int unsigned IMM_OP_HI     = IMM_HI,
  parameter int unsigned LAST_VALID_OP = LAST_OP
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    is_alu,
  output logic                    has_imm,
  output logic                    illegal
);

  localparam logic [OPCODE_WIDTH-1:0] A_LO =
    OPCODE_WIDTH'(ALU_OP_LO);
  localparam logic [OPCODE_WIDTH-1:0] A_HI =
    OPCODE_WIDTH'(ALU_OP_HI);
  localparam logic [OPCODE_WIDTH-1:0] I_LO =
    OPCODE_WIDTH'(IMM_OP_LO);
  localparam logic [OPCODE_WIDTH-1:0] I_HI =
    OPCODE_WIDTH'(IMM_OP_HI);
  localparam logic [OPCODE_WIDTH-1:0] L_OP =
    OPCODE_WIDTH'(LAST_VALID_OP);

  assign is_alu  = (opcode >= A_LO) && (opcode <= A_HI);
  assign has_imm = (opcode >= I_LO) && (opcode <= I_HI);
  assign illegal = (opcode > L_OP);

endmodule

// File: rtl/instr_decoder.sv
// Pipelined instruction decoder: valid/ready word stream in, registered
// decoded fields out (clk, rst_n, flush, in_*, out_*, fields, flags, count).
module instr_decoder
  import cpu_decode_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_W,
  parameter int unsigned OPCODE_WIDTH      = OPC_W,
  parameter int unsigned OPERAND_WIDTH     = OPND_W,
  parameter int unsigned ALU_OP_LO         = ALU_LO,
  parameter int unsigned ALU_OP_HI         = ALU_HI,
  parameter int unsigned IMM_OP_LO         = IMM_LO,
  parameter int unsigned IMM_OP_HI         = IMM_HI,
  parameter int unsigned LAST_VALID_OP     = LAST_OP,
  parameter int unsigned COUNT_WIDTH       = CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [OPERAND_WIDTH-1:0]     destination,
  output logic [OPERAND_WIDTH-1:0]     source_1,
  output logic [OPERAND_WIDTH-1:0]     source_2,
  output logic [INSTRUCTION_WIDTH-1:0] immediate,
  output logic                         is_alu,
  output logic                         has_imm,
  output logic                         illegal,
  output logic [COUNT_WIDTH-1:0]       instr_count
);

  localparam int unsigned IW = INSTRUCTION_WIDTH;
  localparam int unsigned OW = OPCODE_WIDTH;
  localparam int unsigned PW = OPERAND_WIDTH;

  if (OW + 3 * PW != IW) begin : g_bad_width
    $fatal(1, "instr_decoder: field widths do not fill the word");
  end

  if (!(ALU_OP_LO <= ALU_OP_HI &&
        ALU_OP_HI <  IMM_OP_LO &&
        IMM_OP_LO <= IMM_OP_HI &&
        IMM_OP_HI <= LAST_VALID_OP &&
        LAST_VALID_OP < (1 << OW))) begin : g_bad_range
    $fatal(1, "instr_decoder: opcode ranges overlap or misordered");
  end

  logic [OW-1:0] f_op;
  logic [PW-1:0] f_dst;
  logic [PW-1:0] f_s1;
  logic [PW-1:0] f_s2;

  assign f_op  = in_data[IW-1 -: OW];
  assign f_dst = in_data[3*PW-1 -: PW];
  assign f_s1  = in_data[2*PW-1 -: PW];
  assign f_s2  = in_data[PW-1:0];

  logic c_alu;
  logic c_imm;
  logic c_ill;

  opcode_classifier #(
    .OPCODE_WIDTH  (OW),
    .ALU_OP_LO     (ALU_OP_LO),
    .ALU_OP_HI     (ALU_OP_HI),
    .IMM_OP_LO     (IMM_OP_LO),
    .IMM_OP_HI     (IMM_OP_HI),
    .LAST_VALID_OP (LAST_VALID_OP)
  ) u_cls (
    .opcode  (f_op),
    .is_alu  (c_alu),
    .has_imm (c_imm),
    .illegal (c_ill)
  );

  state_t state_q;
  state_t state_d;

  logic          vld_q;
  logic          out_free;
  logic          accept;
  logic          load_op;
  logic          load_pend;
  logic          load_imm;

  logic [OW-1:0] pend_op;
  logic [PW-1:0] pend_dst;
  logic [PW-1:0] pend_s1;
  logic [PW-1:0] pend_s2;

  assign out_free = !vld_q || out_ready;
  assign in_ready = out_free;
  assign accept   = in_valid && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_OP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_OP;
    end else if (accept) begin
      unique case (state_q)
        S_OP:    if (c_imm) state_d = S_IMM;
        S_IMM:   state_d = S_OP;
        default: state_d = S_OP;
      endcase
    end
  end

  // Flush wins: an accepted word in a flush cycle is dropped.
  always_comb begin
    load_op   = 1'b0;
    load_pend = 1'b0;
    load_imm  = 1'b0;
    if (accept && !flush) begin
      unique case (1'b1)
        (state_q == S_IMM):          load_imm  = 1'b1;
        (state_q == S_OP) && c_imm:  load_pend = 1'b1;
        (state_q == S_OP) && !c_imm: load_op   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      opcode      <= '0;
      destination <= '0;
      source_1    <= '0;
      source_2    <= '0;
      immediate   <= '0;
      is_alu      <= 1'b0;
      has_imm     <= 1'b0;
      illegal     <= 1'b0;
      pend_op     <= '0;
      pend_dst    <= '0;
      pend_s1     <= '0;
      pend_s2     <= '0;
      instr_count <= '0;
    end else begin
      if (flush) begin
        vld_q    <= 1'b0;
        pend_op  <= '0;
        pend_dst <= '0;
        pend_s1  <= '0;
        pend_s2  <= '0;
      end else if (load_op) begin
        vld_q       <= 1'b1;
        opcode      <= f_op;
        destination <= f_dst;
        source_1    <= f_s1;
        source_2    <= f_s2;
        immediate   <= '0;
        is_alu      <= c_alu;
        has_imm     <= 1'b0;
        illegal     <= c_ill;
      end else if (load_imm) begin
        // Pending opcode is in the IMM range, so the flags are fixed.
        vld_q       <= 1'b1;
        opcode      <= pend_op;
        destination <= pend_dst;
        source_1    <= pend_s1;
        source_2    <= pend_s2;
        immediate   <= in_data;
        is_alu      <= 1'b0;
        has_imm     <= 1'b1;
        illegal     <= 1'b0;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
      if (load_pend) begin
        pend_op  <= f_op;
        pend_dst <= f_dst;
        pend_s1  <= f_s1;
        pend_s2  <= f_s2;
      end
      if (vld_q && out_ready) begin
        instr_count <= instr_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign out_valid = vld_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: vector table, directed
// corner sequences and a random stream against a word-level model.
module tb_instr_decoder;
  import cpu_decode_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic [8:0]  destination;
  logic [8:0]  source_1;
  logic [8:0]  source_2;
  logic [31:0] immediate;
  logic        is_alu;
  logic        has_imm;
  logic        illegal;
  logic [15:0] instr_count;

  instr_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .destination (destination),
    .source_1    (source_1),
    .source_2    (source_2),
    .immediate   (immediate),
    .is_alu      (is_alu),
    .has_imm     (has_imm),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Word-level reference: pending first word, result slot, handshake count.
  bit          m_wait_imm;
  logic [31:0] m_pend;
  bit          m_valid;
  decoded_t    m_out;
  int unsigned m_count;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned op_of(logic [31:0] w);
    return w / (32'd1 << 27);
  endfunction

  function automatic decoded_t ref_decode(logic [31:0] w,
                                          logic [31:0] imm,
                                          bit with_imm);
    decoded_t d;
    int unsigned op;
    op            = op_of(w);
    d.opcode      = 5'(op);
    d.destination = 9'((w / (32'd1 << 18)) % 512);
    d.source_1    = 9'((w / (32'd1 << 9)) % 512);
    d.source_2    = 9'(w % 512);
    d.immediate   = with_imm ? imm : 32'd0;
    d.is_alu      = (op >= 1) && (op <= 19);
    d.has_imm     = with_imm;
    d.illegal     = (op > 27);
    return d;
  endfunction

  task automatic model_reset();
    m_wait_imm = 0;
    m_pend     = '0;
    m_valid    = 0;
    m_out      = '0;
    m_count    = 0;
  endtask

  // One clock: compare at negedge, advance the model, return at posedge+1.
  task automatic tick();
    bit ofree;
    bit acc;
    int unsigned op;
    @(negedge clk);
    ofree = !m_valid || out_ready;
    chk("in_ready", 32'(in_ready), 32'(ofree));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("instr_count", 32'(instr_count), 32'(m_count % 65536));
    if (m_valid) begin
      chk("opcode", 32'(opcode), 32'(m_out.opcode));
      chk("destination", 32'(destination), 32'(m_out.destination));
      chk("source_1", 32'(source_1), 32'(m_out.source_1));
      chk("source_2", 32'(source_2), 32'(m_out.source_2));
      chk("immediate", immediate, m_out.immediate);
      chk("flags", 32'({is_alu, has_imm, illegal}),
          32'({m_out.is_alu, m_out.has_imm, m_out.illegal}));
    end
    acc = in_valid && ofree;
    op  = op_of(in_data);
    if (m_valid && out_ready) begin
      m_count++;
      m_valid = 0;
    end
    if (flush) begin
      m_wait_imm = 0;
      m_valid    = 0;
    end else if (acc) begin
      if (m_wait_imm) begin
        m_out      = ref_decode(m_pend, in_data, 1);
        m_valid    = 1;
        m_wait_imm = 0;
      end else if (op >= 20 && op <= 23) begin
        m_pend     = in_data;
        m_wait_imm = 1;
      end else begin
        m_out   = ref_decode(in_data, 32'd0, 0);
        m_valid = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] w;
    logic [4:0]  op;
    logic [8:0]  dst;
    logic        alu;
    logic        ill;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h18140E09, 5'd3,  9'd5,   1'b1, 1'b0};
    tbl[1] = '{32'h08000000, 5'd1,  9'd0,   1'b1, 1'b0};
    tbl[2] = '{32'h98000000, 5'd19, 9'd0,   1'b1, 1'b0};
    tbl[3] = '{32'hC8000000, 5'd25, 9'd0,   1'b0, 1'b0};
    tbl[4] = '{32'hD8000000, 5'd27, 9'd0,   1'b0, 1'b0};
    tbl[5] = '{32'hE0000000, 5'd28, 9'd0,   1'b0, 1'b1};
    tbl[6] = '{32'hF0000000, 5'd30, 9'd0,   1'b0, 1'b1};
    tbl[7] = '{32'h00000000, 5'd0,  9'd0,   1'b0, 1'b0};
    tbl[8] = '{32'h07FC0000, 5'd0,  9'd511, 1'b0, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst opcode", 32'(opcode), 32'd0);
    chk("rst immediate", immediate, 32'd0);
    chk("rst count", 32'(instr_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    // First ALU instruction, one-cycle latency.
    in_valid = 1'b1;
    in_data  = 32'h18140E09;
    tick();
    in_valid = 1'b0;
    chk("alu out_valid", 32'(out_valid), 32'd1);
    chk("alu opcode", 32'(opcode), 32'd3);
    chk("alu dst", 32'(destination), 32'd5);
    chk("alu s1", 32'(source_1), 32'd7);
    chk("alu s2", 32'(source_2), 32'd9);
    chk("alu is_alu", 32'(is_alu), 32'd1);
    chk("alu imm", immediate, 32'd0);
    tick();
    chk("alu count", 32'(instr_count), 32'd1);

    // Single-word vector table.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].w;
      tick();
      in_valid = 1'b0;
      chk("tbl out_valid", 32'(out_valid), 32'd1);
      chk("tbl opcode", 32'(opcode), 32'(tbl[i].op));
      chk("tbl dst", 32'(destination), 32'(tbl[i].dst));
      chk("tbl flags", 32'({is_alu, has_imm, illegal}),
          32'({tbl[i].alu, 1'b0, tbl[i].ill}));
      chk("tbl imm", immediate, 32'd0);
      tick();
    end

    // Two-word immediate instruction.
    in_valid = 1'b1;
    in_data  = 32'hA0040000;
    tick();
    chk("imm gap out_valid", 32'(out_valid), 32'd0);
    in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    chk("imm out_valid", 32'(out_valid), 32'd1);
    chk("imm opcode", 32'(opcode), 32'd20);
    chk("imm dst", 32'(destination), 32'd1);
    chk("imm has_imm", 32'(has_imm), 32'd1);
    chk("imm value", immediate, 32'hDEADBEEF);
    tick();

    // Illegal opcode followed back-to-back by an ordinary word.
    in_valid = 1'b1;
    in_data  = 32'hF0000000;
    tick();
    chk("ill flag", 32'(illegal), 32'd1);
    in_data = 32'h18140E09;
    tick();
    in_valid = 1'b0;
    chk("after ill opcode", 32'(opcode), 32'd3);
    chk("after ill imm", immediate, 32'd0);
    tick();

    // Back-pressure: result held, next word queued.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h18140E09;
    tick();
    in_data = 32'h08000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall opcode", 32'(opcode), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("release opcode", 32'(opcode), 32'd1);
    chk("release valid", 32'(out_valid), 32'd1);
    tick();

    // Flush between opcode and immediate word.
    in_valid = 1'b1;
    in_data  = 32'hA0040000;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h18140E09;
    tick();
    in_valid = 1'b0;
    chk("post flush opcode", 32'(opcode), 32'd3);
    chk("post flush has_imm", 32'(has_imm), 32'd0);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      in_data   = $urandom;
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Counter wrap.
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'h18140E09;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("wrap count", 32'(instr_count), 32'd1);

    // Asynchronous reset while waiting for an immediate.
    in_valid = 1'b1;
    in_data  = 32'h18140E09;
    tick();
    in_data = 32'hA0040000;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async opcode", 32'(opcode), 32'd0);
    chk("async dst", 32'(destination), 32'd0);
    chk("async count", 32'(instr_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    chk("post rst opcode", 32'(opcode), 32'd27);
    chk("post rst has_imm", 32'(has_imm), 32'd0);
    chk("post rst imm", immediate, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
